// File: rtl/symbol_packer.sv
// Packs per-axis QAM symbol indices LSB-first into fixed-width words and
// queues them in a small FIFO feeding a valid/ready stream.
module symbol_packer #(
  parameter int MODULATION_ORDER = 16,
  parameter int OUT_WIDTH        = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_dv,
  input  logic [$clog2(MODULATION_ORDER)/2-1:0] in_binary_i,
  input  logic [$clog2(MODULATION_ORDER)/2-1:0] in_binary_q,
  input  logic                               flush,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic [$clog2(OUT_WIDTH+1)-1:0]     out_nbits,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               overflow
);

  localparam int BIT_WIDTH = $clog2(MODULATION_ORDER) / 2;
  localparam int SYM_BITS  = 2 * BIT_WIDTH;
  localparam int ACC_W     = OUT_WIDTH + SYM_BITS;
  localparam int CNT_W     = $clog2(OUT_WIDTH + SYM_BITS + 1);
  localparam int NB_W      = $clog2(OUT_WIDTH + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] OW_C    = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] SB_C    = CNT_W'(SYM_BITS);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
  localparam logic [NB_W-1:0]  FULL_NB = NB_W'(OUT_WIDTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s, acc_abs_s, sym_ext_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_abs_s;

  logic               push_s;
  logic [OUT_WIDTH-1:0] push_data_s;
  logic [NB_W-1:0]    push_nbits_s;
  logic               push_last_s;

  logic [OUT_WIDTH-1:0] mem_data_r  [FIFO_DEPTH];
  logic [NB_W-1:0]      mem_nbits_r [FIFO_DEPTH];
  logic                 mem_last_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic                 overflow_r;
  logic                 full_s, empty_s, pop_s, wr_en_s, drop_s;

  // Accumulator view after absorbing this cycle's symbol (I in the low bits).
  assign sym_ext_s = ACC_W'({in_binary_q, in_binary_i});
  assign acc_abs_s = in_dv ? (acc_r | (sym_ext_s << cnt_r)) : acc_r;
  assign cnt_abs_s = in_dv ? (cnt_r + SB_C) : cnt_r;

  // Next accumulator state and the (at most one) word pushed this cycle.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_abs_s;
    cnt_nxt_s    = cnt_abs_s;
    push_s       = 1'b0;
    push_data_s  = acc_abs_s[OUT_WIDTH-1:0];
    push_nbits_s = FULL_NB;
    push_last_s  = 1'b0;
    case (state_r)
      FLUSH: begin
        // Remainder of a straddled flush leaves now; a new symbol opens a fresh word.
        push_s       = 1'b1;
        push_data_s  = acc_r[OUT_WIDTH-1:0];
        push_nbits_s = NB_W'(cnt_r);
        push_last_s  = 1'b1;
        state_nxt_s  = ACCUM;
        if (in_dv) begin
          acc_nxt_s = sym_ext_s;
          cnt_nxt_s = SB_C;
        end else begin
          acc_nxt_s = '0;
          cnt_nxt_s = ZERO_C;
        end
      end
      ACCUM: begin
        if (flush && (cnt_abs_s != ZERO_C)) begin
          push_s = 1'b1;
          if (cnt_abs_s == OW_C) begin
            push_last_s = 1'b1;
            acc_nxt_s   = '0;
            cnt_nxt_s   = ZERO_C;
          end else if (cnt_abs_s > OW_C) begin
            acc_nxt_s   = acc_abs_s >> OUT_WIDTH;
            cnt_nxt_s   = cnt_abs_s - OW_C;
            state_nxt_s = FLUSH;
          end else begin
            push_nbits_s = NB_W'(cnt_abs_s);
            push_last_s  = 1'b1;
            acc_nxt_s    = '0;
            cnt_nxt_s    = ZERO_C;
          end
        end else if (cnt_abs_s >= OW_C) begin
          push_s    = 1'b1;
          acc_nxt_s = acc_abs_s >> OUT_WIDTH;
          cnt_nxt_s = cnt_abs_s - OW_C;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
        acc_nxt_s   = '0;
        cnt_nxt_s   = ZERO_C;
      end
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= '0;
      cnt_r   <= ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == DEPTH_C);
  assign pop_s   = !empty_s && out_ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Output FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i]  <= '0;
        mem_nbits_r[i] <= '0;
        mem_last_r[i]  <= 1'b0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_data_r[wr_ptr_r]  <= push_data_s;
        mem_nbits_r[wr_ptr_r] <= push_nbits_s;
        mem_last_r[wr_ptr_r]  <= push_last_s;
        wr_ptr_r              <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign out_data  = mem_data_r[rd_ptr_r];
  assign out_nbits = mem_nbits_r[rd_ptr_r];
  assign out_last  = mem_last_r[rd_ptr_r];
  assign out_valid = !empty_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: a 16-QAM and a 64-QAM instance checked
// every cycle against a bit-count/queue model plus hand-computed beats.
module tb_symbol_packer;

  logic clk = 1'b0;
  logic rst, ready;
  logic dv16, fl16, dv64, fl64;
  logic [1:0] i16, q16;
  logic [2:0] i64, q64;
  logic [7:0] d16, d64;
  logic [3:0] n16, n64;
  logic l16, v16, o16, l64, v64, o64;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: pending bits as an integer + bit count, FIFO as a shift array.
  longint macc[2];
  int     mcnt[2];
  bit     mpend[2];
  int     fd[2][8];
  int     fn[2][8];
  bit     fl[2][8];
  int     fc[2];
  bit     movf[2];

  // Beats accepted by the sink, per instance.
  int log_d[2][16];
  int log_n[2][16];
  bit log_l[2][16];
  int log_cnt[2];

  always #5 clk = ~clk;

  symbol_packer #(.MODULATION_ORDER(16), .OUT_WIDTH(8), .FIFO_DEPTH(4)) u_p16 (
    .clk(clk), .rst(rst), .in_dv(dv16), .in_binary_i(i16), .in_binary_q(q16),
    .flush(fl16), .out_data(d16), .out_nbits(n16), .out_last(l16),
    .out_valid(v16), .out_ready(ready), .overflow(o16));

  symbol_packer #(.MODULATION_ORDER(64), .OUT_WIDTH(8), .FIFO_DEPTH(4)) u_p64 (
    .clk(clk), .rst(rst), .in_dv(dv64), .in_binary_i(i64), .in_binary_q(q64),
    .flush(fl64), .out_data(d64), .out_nbits(n64), .out_last(l64),
    .out_valid(v64), .out_ready(ready), .overflow(o64));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int sb, input bit r, input bit dv,
                            input bit f, input bit rdy, input int sym);
    bit pop, push, plast;
    int pdat, pnb;
    if (r) begin
      macc[k] = 0; mcnt[k] = 0; mpend[k] = 0; fc[k] = 0; movf[k] = 0;
      return;
    end
    pop = (fc[k] > 0) && rdy;
    push = 0; pdat = 0; pnb = 0; plast = 0;
    if (mpend[k]) begin
      push = 1; pdat = int'(macc[k] & 255); pnb = mcnt[k]; plast = 1;
      mpend[k] = 0;
      macc[k] = dv ? longint'(sym) : 0;
      mcnt[k] = dv ? sb : 0;
    end else begin
      if (dv) begin
        macc[k] = macc[k] | (longint'(sym) << mcnt[k]);
        mcnt[k] = mcnt[k] + sb;
      end
      if (f && mcnt[k] > 0) begin
        push = 1; pdat = int'(macc[k] & 255);
        pnb = (mcnt[k] >= 8) ? 8 : mcnt[k];
        plast = (mcnt[k] <= 8);
        if (mcnt[k] > 8) begin
          macc[k] = macc[k] >> 8; mcnt[k] = mcnt[k] - 8; mpend[k] = 1;
        end else begin
          macc[k] = 0; mcnt[k] = 0;
        end
      end else if (!f && mcnt[k] >= 8) begin
        push = 1; pdat = int'(macc[k] & 255); pnb = 8; plast = 0;
        macc[k] = macc[k] >> 8; mcnt[k] = mcnt[k] - 8;
      end
    end
    if (pop) begin
      for (int j = 0; j < 7; j++) begin
        fd[k][j] = fd[k][j+1]; fn[k][j] = fn[k][j+1]; fl[k][j] = fl[k][j+1];
      end
      fc[k]--;
    end
    if (push) begin
      if (fc[k] < 4) begin
        fd[k][fc[k]] = pdat; fn[k][fc[k]] = pnb; fl[k][fc[k]] = plast;
        fc[k]++;
      end else begin
        movf[k] = 1;
      end
    end
  endtask

  // Advance the model on the same edge the DUTs sample.
  always @(posedge clk) begin
    model_step(0, 4, rst, dv16, fl16, ready, int'({q16, i16}));
    model_step(1, 6, rst, dv64, fl64, ready, int'({q64, i64}));
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid16", v16, fc[0] > 0);
      chk("ovf16", o16, movf[0]);
      if (v16) begin
        chk("data16", d16, fd[0][0]);
        chk("nbits16", n16, fn[0][0]);
        chk("last16", l16, fl[0][0]);
      end
      chk("valid64", v64, fc[1] > 0);
      chk("ovf64", o64, movf[1]);
      if (v64) begin
        chk("data64", d64, fd[1][0]);
        chk("nbits64", n64, fn[1][0]);
        chk("last64", l64, fl[1][0]);
      end
      if (!rst && ready && v16 && log_cnt[0] < 16) begin
        log_d[0][log_cnt[0]] = d16; log_n[0][log_cnt[0]] = n16;
        log_l[0][log_cnt[0]] = l16; log_cnt[0]++;
      end
      if (!rst && ready && v64 && log_cnt[1] < 16) begin
        log_d[1][log_cnt[1]] = d64; log_n[1][log_cnt[1]] = n64;
        log_l[1][log_cnt[1]] = l64; log_cnt[1]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dv16 = 1'b0; fl16 = 1'b0; dv64 = 1'b0; fl64 = 1'b0;
  endtask

  task automatic s16(input int sym, input bit f);
    dv16 = 1'b1; i16 = sym[1:0]; q16 = sym[3:2]; fl16 = f;
    tick();
  endtask

  task automatic s64(input int sym, input bit f);
    dv64 = 1'b1; i64 = sym[2:0]; q64 = sym[5:3]; fl64 = f;
    tick();
  endtask

  task automatic beat16(input string name, input int d, input int n, input bit l);
    @(negedge clk);
    chk({name, "_v"}, v16, 1);
    chk({name, "_d"}, d16, d);
    chk({name, "_n"}, n16, n);
    chk({name, "_l"}, l16, l);
  endtask

  task automatic beat64(input string name, input int d, input int n, input bit l);
    @(negedge clk);
    chk({name, "_v"}, v64, 1);
    chk({name, "_d"}, d64, d);
    chk({name, "_n"}, n64, n);
    chk({name, "_l"}, l64, l);
  endtask

  // Hand-computed accepted-beat sequences.
  int exp16_d[7] = '{8'h39, 8'h09, 8'h39, 8'h10, 8'h21, 8'h32, 8'h43};
  int exp16_n[7] = '{8, 4, 8, 8, 8, 8, 8};
  bit exp16_l[7] = '{0, 1, 1, 0, 0, 0, 0};
  int exp64_d[6] = '{8'h3F, 8'h50, 8'hA9, 8'h7F, 8'h05, 8'h2A};
  int exp64_n[6] = '{8, 8, 8, 8, 4, 6};
  bit exp64_l[6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    // Reset held three cycles with random inputs.
    for (int c = 0; c < 3; c++) begin
      dv16 = 1'($urandom); fl16 = 1'($urandom); dv64 = 1'($urandom); fl64 = 1'($urandom);
      i16 = 2'($urandom); q16 = 2'($urandom); i64 = 3'($urandom); q64 = 3'($urandom);
      ready = 1'($urandom);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
    end
    @(negedge clk);
    chk("rst_v16", v16, 0); chk("rst_d16", d16, 0); chk("rst_n16", n16, 0);
    chk("rst_l16", l16, 0); chk("rst_o16", o16, 0);
    chk("rst_v64", v64, 0); chk("rst_d64", d64, 0); chk("rst_o64", o64, 0);
    rst = 1'b0; ready = 1'b1;
    dv16 = 1'b0; fl16 = 1'b0; dv64 = 1'b0; fl64 = 1'b0;
    i16 = 2'd0; q16 = 2'd0; i64 = 3'd0; q64 = 3'd0;
    tick();

    // Two 16-QAM symbols fill one word.
    s16(4'h9, 1'b0);
    s16(4'h3, 1'b0);
    beat16("full", 8'h39, 8, 1'b0);
    tick();
    @(negedge clk);
    chk("one_beat", v16, 0);

    // Partial word on flush; second flush with empty accumulator is a no-op.
    s16(4'h9, 1'b0);
    fl16 = 1'b1; tick();
    beat16("partial", 8'h09, 4, 1'b1);
    fl16 = 1'b1; tick();
    @(negedge clk);
    chk("noop_flush_a", v16, 0);
    tick();
    @(negedge clk);
    chk("noop_flush_b", v16, 0);

    // Symbol + flush completing exactly one word.
    s16(4'h9, 1'b0);
    s16(4'h3, 1'b1);
    beat16("exact", 8'h39, 8, 1'b1);
    tick();

    // 64-QAM straddling, then flush straddle and FLUSH-state coincidences.
    s64(6'h3F, 1'b0);
    s64(6'h00, 1'b0);
    s64(6'h15, 1'b0);
    s64(6'h2A, 1'b0);
    beat64("m64_a9", 8'hA9, 8, 1'b0);
    s64(6'h3F, 1'b0);
    s64(6'h15, 1'b1);
    beat64("straddle", 8'h7F, 8, 1'b0);
    s64(6'h2A, 1'b1);
    beat64("remainder", 8'h05, 4, 1'b1);
    fl64 = 1'b1; tick();
    beat64("fresh", 8'h2A, 6, 1'b1);
    tick(); tick();

    // Overflow: six words into a four-deep FIFO with the sink stalled.
    ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      s16(w, 1'b0);
      s16(w + 1, 1'b0);
    end
    @(negedge clk);
    chk("ovf_set", o16, 1);
    chk("ovf_valid", v16, 1);
    chk("ovf_head", d16, 8'h10);
    ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    @(negedge clk);
    chk("drained", v16, 0);
    chk("ovf_sticky", o16, 1);

    // Mid-operation reset discards a queued word and clears overflow.
    ready = 1'b0;
    s16(4'h5, 1'b0);
    s16(4'h6, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_v", v16, 0);
    chk("mid_rst_o", o16, 0);
    tick();
    @(negedge clk);
    chk("post_rst_v", v16, 0);
    ready = 1'b1;
    tick();

    chk("log16_len", log_cnt[0], 7);
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("log16_d%0d", j), log_d[0][j], exp16_d[j]);
      chk($sformatf("log16_n%0d", j), log_n[0][j], exp16_n[j]);
      chk($sformatf("log16_l%0d", j), log_l[0][j], exp16_l[j]);
    end
    chk("log64_len", log_cnt[1], 6);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("log64_d%0d", j), log_d[1][j], exp64_d[j]);
      chk($sformatf("log64_n%0d", j), log_n[1][j], exp64_n[j]);
      chk($sformatf("log64_l%0d", j), log_l[1][j], exp64_l[j]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
